// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seg_pkg
//  Purpose  : Shared types and constants for the 7-segment pattern sequencer.
//             Holds the four active-low glyph patterns ({g,f,e,d,c,b,a}),
//             the 2-bit glyph code type and the ping-pong phase type.
//  Revision : 1.0 - initial release
// ============================================================================
package seg_pkg;

    // Index into the glyph table
    typedef logic [1:0] glyph_code_t;

    // Direction of travel while in ping-pong mode
    typedef enum logic {
        PHASE_UP   = 1'b0,
        PHASE_DOWN = 1'b1
    } phase_t;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] GLYPH_0 = 7'b1000000;
    localparam logic [6:0] GLYPH_1 = 7'b0000000;
    localparam logic [6:0] GLYPH_2 = 7'b0010010;
    localparam logic [6:0] GLYPH_3 = 7'b1011000;

endpackage
`default_nettype wire

// File: rtl/seg_glyph_dec.sv
`default_nettype none
// ============================================================================
//  Module   : seg_glyph_dec
//  Purpose  : Combinational glyph decoder, 2-bit glyph code to 7-bit
//             active-low segment pattern.
//  Ports    : code    - glyph code 0..3
//             pattern - active-low segments {g,f,e,d,c,b,a}
//  Revision : 1.0 - initial release
// ============================================================================
module seg_glyph_dec
    import seg_pkg::*;
(
    input  glyph_code_t code,
    output logic [6:0]  pattern
);

    always_comb begin
        pattern = GLYPH_0;
        case (code)
            2'd0: pattern = GLYPH_0;
            2'd1: pattern = GLYPH_1;
            2'd2: pattern = GLYPH_2;
            2'd3: pattern = GLYPH_3;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seg_pattern_seq.sv
`default_nettype none
// ============================================================================
//  Module   : seg_pattern_seq
//  Purpose  : Steps through a STEPS-long sequence once every DIV enabled clock
//             cycles and shows a rotating glyph pattern on NUM_DIGITS
//             7-segment digits. Supports wrap (up/down) and ping-pong modes.
//  Ports    : clk    - clock, all state on rising edge
//             rst    - asynchronous active-low reset
//             en     - prescaler enable; low freezes prescaler, step, phase
//             dir    - wrap-mode direction (0 up, 1 down)
//             bounce - 0 wrap mode, 1 ping-pong mode
//             rot    - per-digit glyph rotation offset
//             blank  - forces all segments off (registered)
//             seg    - active-low segments, digit 0 in bits [6:0]
//             step   - current step index
//             tick   - one-cycle pulse, coincident with each step advance
//  Revision : 1.0 - initial release
// ============================================================================
module seg_pattern_seq
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 3,
    parameter int STEPS      = 7,
    parameter int DIV        = 2**24
)(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        dir,
    input  logic                        bounce,
    input  logic [1:0]                  rot,
    input  logic                        blank,
    output logic [7*NUM_DIGITS-1:0]     seg,
    output logic [$clog2(STEPS)-1:0]    step,
    output logic                        tick
);

    localparam int PW = $clog2(DIV);
    localparam int SW = $clog2(STEPS);

    localparam logic [PW-1:0] PRESC_LAST  = PW'(DIV - 1);
    localparam logic [SW-1:0] STEP_LAST   = SW'(STEPS - 1);
    localparam logic [SW-1:0] STEP_PENULT = SW'(STEPS - 2);
    localparam logic [SW-1:0] STEP_ONE    = SW'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PW-1:0] presc, presc_nxt;
    logic [SW-1:0] step_nxt;
    phase_t        phase, phase_nxt, eff_phase;
    logic          bounce_prev, bounce_prev_nxt;
    logic          tick_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc       <= '0;
            step        <= '0;
            phase       <= PHASE_UP;
            bounce_prev <= 1'b0;
            tick        <= 1'b0;
        end else begin
            presc       <= presc_nxt;
            step        <= step_nxt;
            phase       <= phase_nxt;
            bounce_prev <= bounce_prev_nxt;
            tick        <= tick_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state: prescaler, step and ping-pong phase
    // ------------------------------------------------------------------
    always_comb begin
        presc_nxt       = presc;
        step_nxt        = step;
        phase_nxt       = phase;
        bounce_prev_nxt = bounce_prev;
        tick_nxt        = 1'b0;
        eff_phase       = phase;

        if (en) begin
            // The bounce edge detector only advances while enabled, so a
            // mode change made while frozen takes effect on the first
            // enabled cycle and phase is never altered during a freeze.
            bounce_prev_nxt = bounce;
            if (bounce && !bounce_prev) begin
                eff_phase = phase_t'(dir);
            end
            phase_nxt = eff_phase;

            if (presc == PRESC_LAST) begin
                presc_nxt = '0;
                tick_nxt  = 1'b1;

                if (bounce) begin
                    // Reflect at the ends so neither end step is repeated
                    if (eff_phase == PHASE_UP) begin
                        if (step == STEP_LAST) begin
                            step_nxt  = STEP_PENULT;
                            phase_nxt = PHASE_DOWN;
                        end else begin
                            step_nxt = step + 1'b1;
                        end
                    end else begin
                        if (step == '0) begin
                            step_nxt  = STEP_ONE;
                            phase_nxt = PHASE_UP;
                        end else begin
                            step_nxt = step - 1'b1;
                        end
                    end
                end else if (dir) begin
                    step_nxt = (step == '0) ? STEP_LAST : step - 1'b1;
                end else begin
                    step_nxt = (step == STEP_LAST) ? '0 : step + 1'b1;
                end
            end else begin
                presc_nxt = presc + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Glyph selection: code for digit d = (step + d*rot) mod 4.
    // Only the two low step bits matter for a mod-4 result.
    // ------------------------------------------------------------------
    glyph_code_t step_lo;

    if (SW >= 2) begin : g_step_lo_wide
        assign step_lo = step[1:0];
    end else begin : g_step_lo_narrow
        assign step_lo = {1'b0, step[0]};
    end

    logic [7*NUM_DIGITS-1:0] glyph_bus;

    for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_digit
        glyph_code_t code;

        assign code = step_lo + glyph_code_t'(d) * rot;

        seg_glyph_dec u_dec (
            .code    (code),
            .pattern (glyph_bus[7*d +: 7])
        );
    end

    // Registered segment drive: follows step/rot/blank by one cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg <= {NUM_DIGITS{GLYPH_0}};
        end else if (blank) begin
            seg <= '1;
        end else begin
            seg <= glyph_bus;
        end
    end

endmodule
`default_nettype wire
